// File: rtl/lfsr_range_sampler_pkg.sv
// Shared constants and helpers for the LFSR range sampler.
//   clog2()          : constant ceiling log2 used for widths
//   range_legal()    : RANGE must lie in 2..65536
//   depth_legal()    : DEPTH must be a power of two in 2..16
//   REJECT_CNT_W/SAT : rejection counter width and saturation value
//   WRAP_CNT_W       : LFSR period counter width
package lfsr_range_sampler_pkg;

    localparam int unsigned LFSR_W       = 17;
    localparam int unsigned REJECT_CNT_W = 16;
    localparam logic [REJECT_CNT_W-1:0] REJECT_SAT = 16'hFFFF;
    localparam int unsigned WRAP_CNT_W   = 8;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((longint'(1) << r) < longint'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit range_legal(input int unsigned r);
        return (r >= 2) && (r <= 65536);
    endfunction

    function automatic bit depth_legal(input int unsigned d);
        return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/lfsr_range_sampler_if.sv
// Valid/ready handshake carrying accepted random values to the consumer.
//   rnd_data  : FIFO head value
//   rnd_valid : FIFO non-empty
//   rnd_ready : consumer takes rnd_data when rnd_valid & rnd_ready
interface lfsr_range_sampler_if #(
    parameter int unsigned W = 4
) ();
    logic [W-1:0] rnd_data;
    logic         rnd_valid;
    logic         rnd_ready;

    modport master (output rnd_data, output rnd_valid, input rnd_ready);
    modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/lfsr_range_sampler_sync_fifo_fwft.sv
// First-word-fall-through FIFO, circular buffer with wrapping pointers.
//   push/push_data : write (never issued when full)
//   pop            : read-advance, ignored when empty
//   head_data      : oldest entry (0 after reset)
//   count          : occupancy 0..DEPTH
module sync_fifo_fwft
    import lfsr_range_sampler_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;

    assign pop_ok    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is 2**AW.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lfsr_range_sampler.sv
// Samples a 17-bit LFSR, maps samples into [0, RANGE-1] by rejection and
// buffers accepted values in a FWFT FIFO.
//   en            : enables sampling (sh_en), FIFO reads continue regardless
//   lfsr_q        : LFSR state; lfsr_max_tick : LFSR back at its seed
//   sh_en         : combinational shift request to the LFSR
//   rnd           : valid/ready output handshake
//   fifo_count    : FIFO occupancy
//   reject_cnt    : saturating rejected-sample count
//   wrap_cnt      : wrapping count of LFSR periods
module lfsr_range_sampler
    import lfsr_range_sampler_pkg::*;
#(
    parameter int unsigned RANGE = 10,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned W    = clog2(RANGE),
    localparam int unsigned CW   = clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [LFSR_W-1:0]       lfsr_q,
    input  logic                    lfsr_max_tick,
    output logic                    sh_en,
    lfsr_range_sampler_if.master    rnd,
    output logic [CW-1:0]           fifo_count,
    output logic [REJECT_CNT_W-1:0] reject_cnt,
    output logic [WRAP_CNT_W-1:0]   wrap_cnt
);

    if (!range_legal(RANGE)) begin : g_bad_range
        $error("lfsr_range_sampler: RANGE out of 2..65536");
    end
    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("lfsr_range_sampler: DEPTH must be a power of two in 2..16");
    end

    localparam bit RANGE_POW2 = (longint'(RANGE) == (longint'(1) << W));

    logic         s1_vld;
    logic [W-1:0] s1_val;
    logic         in_range;
    logic         accept;
    logic         reject;
    logic         pop;
    logic         unused_lfsr_hi;

    assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:W];

    // Count the in-flight sample against free space so a push never hits a full FIFO.
    assign sh_en = en && !rst_n &&
                   (({1'b0, fifo_count} + (CW+1)'(s1_vld)) < (CW+1)'(DEPTH));

    // Stage 1: capture the slice present in the same cycle the shift is requested.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_vld <= 1'b0;
            s1_val <= '0;
        end else begin
            s1_vld <= sh_en;
            if (sh_en) begin
                s1_val <= lfsr_q[W-1:0];
            end
        end
    end

    // Stage 2: a W-bit slice can never reach RANGE when RANGE is 2**W.
    assign in_range = RANGE_POW2 ? 1'b1 : (s1_val < W'(RANGE));
    assign accept   = s1_vld && in_range;
    assign reject   = s1_vld && !in_range;

    assign pop           = rnd.rnd_valid && rnd.rnd_ready;
    assign rnd.rnd_valid = (fifo_count != '0);

    sync_fifo_fwft #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (s1_val),
        .pop       (pop),
        .head_data (rnd.rnd_data),
        .count     (fifo_count)
    );

    // Statistics: saturating rejects, wrapping LFSR periods (independent of en).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            reject_cnt <= '0;
            wrap_cnt   <= '0;
        end else begin
            if (reject && (reject_cnt != REJECT_SAT)) begin
                reject_cnt <= reject_cnt + REJECT_CNT_W'(1);
            end
            if (lfsr_max_tick) begin
                wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Directed bench for lfsr_range_sampler (RANGE=10, DEPTH=4).
module tb_lfsr_range_sampler;
    import lfsr_range_sampler_pkg::*;

    localparam int unsigned RANGE = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = clog2(RANGE);
    localparam int unsigned CW    = clog2(DEPTH) + 1;

    logic                    clk;
    logic                    rst_n;
    logic                    en;
    logic [LFSR_W-1:0]       lfsr_q;
    logic                    lfsr_max_tick;
    logic                    sh_en;
    logic [CW-1:0]           fifo_count;
    logic [REJECT_CNT_W-1:0] reject_cnt;
    logic [WRAP_CNT_W-1:0]   wrap_cnt;

    int checks;
    int errors;

    lfsr_range_sampler_if #(.W(W)) rnd_bus ();

    lfsr_range_sampler #(
        .RANGE (RANGE),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .lfsr_q        (lfsr_q),
        .lfsr_max_tick (lfsr_max_tick),
        .sh_en         (sh_en),
        .rnd           (rnd_bus),
        .fifo_count    (fifo_count),
        .reject_cnt    (reject_cnt),
        .wrap_cnt      (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b1;
        en            = 1'b1;
        rnd_bus.rnd_ready = 1'b0;
        lfsr_q        = '0;
        lfsr_max_tick = 1'b0;

        // Reset state; sh_en held low by reset even with en=1
        step();
        step();
        check("rst_count", 32'(fifo_count), 0);
        check("rst_valid", 32'(rnd_bus.rnd_valid), 0);
        check("rst_data", 32'(rnd_bus.rnd_data), 0);
        check("rst_reject", 32'(reject_cnt), 0);
        check("rst_wrap", 32'(wrap_cnt), 0);
        check("rst_sh_en", 32'(sh_en), 0);

        // First sample latency
        rst_n = 1'b0;
        rnd_bus.rnd_ready = 1'b1;
        lfsr_q = 17'h00003;
        #1;
        check("t1_sh_en", 32'(sh_en), 1);
        step();
        check("t1_valid_n", 32'(rnd_bus.rnd_valid), 0);
        step();
        check("t1_valid_n1", 32'(rnd_bus.rnd_valid), 1);
        check("t1_data", 32'(rnd_bus.rnd_data), 3);
        en = 1'b0;
        repeat (3) step();
        check("t1_drain", 32'(fifo_count), 0);

        // Rejection of 12, acceptance of 7
        en = 1'b1;
        lfsr_q = 17'h0000C;
        step();
        lfsr_q = 17'h00007;
        step();
        check("t2_reject", 32'(reject_cnt), 1);
        check("t2_no12", 32'(rnd_bus.rnd_valid), 0);
        step();
        check("t2_valid", 32'(rnd_bus.rnd_valid), 1);
        check("t2_data7", 32'(rnd_bus.rnd_data), 7);
        en = 1'b0;
        repeat (3) step();
        check("t2_drain", 32'(fifo_count), 0);

        // Fill with consumer stalled: only 1..4 enter, sh_en backs off
        rnd_bus.rnd_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lfsr_q = 17'(i + 1);
            step();
        end
        check("t3_full", 32'(fifo_count), 4);
        check("t3_sh_en", 32'(sh_en), 0);
        check("t3_reject", 32'(reject_cnt), 1);
        en = 1'b0;
        rnd_bus.rnd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_order", 32'(rnd_bus.rnd_data), 32'(i + 1));
            step();
        end
        check("t3_empty", 32'(rnd_bus.rnd_valid), 0);

        // Simultaneous push and pop with two buffered
        rnd_bus.rnd_ready = 1'b0;
        en = 1'b1;
        lfsr_q = 17'h00008;
        step();
        lfsr_q = 17'h00009;
        step();
        lfsr_q = 17'h00005;
        step();
        check("t4_two", 32'(fifo_count), 2);
        check("t4_head8", 32'(rnd_bus.rnd_data), 8);
        en = 1'b0;
        rnd_bus.rnd_ready = 1'b1;
        step();
        check("t4_count", 32'(fifo_count), 2);
        check("t4_head9", 32'(rnd_bus.rnd_data), 9);
        step();
        check("t4_head5", 32'(rnd_bus.rnd_data), 5);
        step();
        check("t4_drain", 32'(fifo_count), 0);

        // wrap_cnt wraps after 256 ticks
        lfsr_max_tick = 1'b1;
        repeat (255) step();
        check("t5_wrap255", 32'(wrap_cnt), 255);
        step();
        check("t5_wrap0", 32'(wrap_cnt), 0);
        lfsr_max_tick = 1'b0;

        // 70000 rejects saturate reject_cnt
        en = 1'b1;
        lfsr_q = 17'h0000F;
        repeat (70000) step();
        check("t5_sat", 32'(reject_cnt), 32'hFFFF);
        check("t5_none", 32'(rnd_bus.rnd_valid), 0);

        // Reset with three buffered and one in flight
        en = 1'b0;
        repeat (2) step();
        en = 1'b1;
        rnd_bus.rnd_ready = 1'b0;
        lfsr_q = 17'h00002;
        repeat (4) step();
        check("t6_three", 32'(fifo_count), 3);
        rst_n = 1'b1;
        #1;
        check("t6_sh_en", 32'(sh_en), 0);
        step();
        check("t6_count", 32'(fifo_count), 0);
        check("t6_valid", 32'(rnd_bus.rnd_valid), 0);
        check("t6_reject", 32'(reject_cnt), 0);
        check("t6_data", 32'(rnd_bus.rnd_data), 0);
        rst_n = 1'b0;
        en = 1'b0;
        step();
        check("t6_no_push", 32'(fifo_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_range_sampler.md
Name: lfsr_range_sampler

Overview:
Downstream consumer of the 17-bit LFSR.
- Drives the LFSR shift enable and samples its state.
- Maps each sample into the uniform range [0, RANGE-1] by rejection sampling.
- Buffers accepted values in a small first-word-fall-through FIFO, read via a valid/ready handshake (game logic, LED pattern selection).
- Reports rejection statistics and counts full LFSR periods.

Parameters:
RANGE, 10, size of the output range; legal 2..65536.
DEPTH, 4, FIFO entries; power of two, 2..16.
W, clog2(RANGE), localparam: width of rnd_data and of the sampled LFSR slice.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-high reset (name kept per codebase convention; asserted = 1)
en  in  1  enables sampling; low freezes sh_en but not FIFO reads
lfsr_q  in  17  current LFSR state
lfsr_max_tick  in  1  pulse from the LFSR when its state equals the seed
sh_en  out  1  shift request to the LFSR, combinational
rnd_data  out  W  FIFO head value
rnd_valid  out  1  FIFO non-empty
rnd_ready  in  1  consumer accepts rnd_data when rnd_valid & rnd_ready
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
reject_cnt  out  16  rejected samples, saturates at 16'hFFFF
wrap_cnt  out  8  count of lfsr_max_tick pulses, wraps 255->0

Behaviour:
- Reset (rst_n=1 at a clock edge): FIFO empty, fifo_count=0, rnd_valid=0, s1_vld=0, reject_cnt=0, wrap_cnt=0.
  - rnd_data is don't-care while rnd_valid=0; it must read 0 after reset.
  - sh_en=0 during reset.
  - Reset mid-operation discards all buffered and in-flight samples with no partial pushes.
- sh_en = en & ~rst_n & ((fifo_count + s1_vld) < DEPTH). This reserves a slot for the in-flight sample, so the FIFO can never overflow.
- Stage 1, at each edge:
  - s1_vld <= sh_en.
  - If sh_en=1, s1_val <= lfsr_q[W-1:0], i.e. the LFSR value present in the same cycle it is asked to shift.
- Stage 2 (combinational on s1):
  - accept = s1_vld & (s1_val < RANGE), compared as W-bit unsigned.
  - reject = s1_vld & ~accept.
  - accept pushes s1_val into the FIFO.
  - reject increments reject_cnt, saturating at 16'hFFFF.
  - For RANGE a power of two, reject is constant 0.
- FIFO: first-word-fall-through.
  - rnd_valid = (fifo_count != 0).
  - pop = rnd_valid & rnd_ready.
  - Push and pop in the same cycle leave the count unchanged and preserve order.
  - Pop when empty is ignored. Push never occurs when full, guaranteed by sh_en.
- Latency: sample captured at edge N, pushed at edge N+1, visible on rnd_valid/rnd_data after edge N+1. Minimum 2 cycles from sh_en high to first rnd_valid.
- Throughput: 1 value/cycle when RANGE is a power of two and rnd_ready is held high.
- wrap_cnt increments on every cycle with lfsr_max_tick=1, independent of en.
- en falling: sh_en drops immediately; an in-flight s1 sample is still processed.

Decomposition:
- Shared package: DEPTH/RANGE legality checks, the clog2 function, the reject_cnt width constant (16) and saturation value, the wrap_cnt width (8).
- Sub-module: sync_fifo_fwft (parameters WIDTH, DEPTH).
  - Ports: clk, rst_n, push, push_data, pop, head_data, count.
  - Synchronous active-high reset.
  - Circular buffer with wrap-around pointers.

Test Plan:
- Reset, then en=1, rnd_ready=1, lfsr_q=17'h00003 held -> sh_en=1; rnd_valid=1 with rnd_data=4'd3 two cycles after the first sampling edge.
- RANGE=10, lfsr_q=17'h0000C for one sample, then 17'h00007 -> reject_cnt=1, 12 never appears, next rnd_data=7.
- rnd_ready=0, en=1, lfsr_q cycling legal values -> fifo_count reaches 4 and sh_en=0; no overflow; then rnd_ready=1 pops values in push order.
- FIFO holding 2, push and pop in the same cycle -> fifo_count stays 2; head advances to the second entry.
- 256 lfsr_max_tick pulses -> wrap_cnt returns to 0; 70000 forced rejects -> reject_cnt holds 16'hFFFF.
- rst_n=1 asserted with FIFO at 3 and s1_vld=1 -> next cycle fifo_count=0, rnd_valid=0, reject_cnt=0, sh_en=0.
